// File: rtl/alu_pkg.sv
// Shared opcode encodings, FSM state type and default iteration count for
// the multicycle ALU and its iterative multiply/divide datapath.
package alu_pkg;

  localparam int ITER_DEFAULT = 32;

  localparam logic [3:0] OP_ADD  = 4'h0;
  localparam logic [3:0] OP_SUB  = 4'h1;
  localparam logic [3:0] OP_AND  = 4'h2;
  localparam logic [3:0] OP_OR   = 4'h3;
  localparam logic [3:0] OP_XOR  = 4'h4;
  localparam logic [3:0] OP_NOR  = 4'h5;
  localparam logic [3:0] OP_SLT  = 4'h6;
  localparam logic [3:0] OP_SLTU = 4'h7;
  localparam logic [3:0] OP_SLL  = 4'h8;
  localparam logic [3:0] OP_SRL  = 4'h9;
  localparam logic [3:0] OP_SRA  = 4'hA;
  localparam logic [3:0] OP_MULT = 4'hB;
  localparam logic [3:0] OP_MULTU= 4'hC;
  localparam logic [3:0] OP_DIV  = 4'hD;
  localparam logic [3:0] OP_DIVU = 4'hE;
  localparam logic [3:0] OP_RSVD = 4'hF;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CALC = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  function automatic logic is_multicycle(input logic [3:0] op);
    return (op >= OP_MULT) && (op <= OP_DIVU);
  endfunction

endpackage

// File: rtl/mul_div_iter.sv
// Iterative shift-add multiplier / restoring divider on operand magnitudes,
// with sign fix-up applied to the value produced by the final iteration.
module mul_div_iter #(
  parameter int WIDTH = 32
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               i_start,
  input  logic               i_step,
  input  logic               i_signed,
  input  logic               i_div,
  input  logic [WIDTH-1:0]   i_a,
  input  logic [WIDTH-1:0]   i_b,
  output logic [2*WIDTH-1:0] o_result
);

  logic [2*WIDTH-1:0] r_acc;
  logic [WIDTH-1:0]   r_operand;
  logic [WIDTH-1:0]   r_dividend;
  logic               r_div;
  logic               r_neg_q;
  logic               r_neg_r;
  logic               r_div_zero;

  logic [WIDTH-1:0]   w_a_mag;
  logic [WIDTH-1:0]   w_b_mag;
  logic [WIDTH:0]     w_sum;
  logic [WIDTH:0]     w_shift;
  logic [WIDTH:0]     w_diff;
  logic               w_ge;
  logic [2*WIDTH-1:0] w_acc_next;
  logic [WIDTH-1:0]   w_quo;
  logic [WIDTH-1:0]   w_rem;
  logic [WIDTH-1:0]   w_quo_fix;
  logic [WIDTH-1:0]   w_rem_fix;

  always_comb begin
    w_a_mag = (i_signed && i_a[WIDTH-1]) ? -i_a : i_a;
    w_b_mag = (i_signed && i_b[WIDTH-1]) ? -i_b : i_b;
  end

  // Multiply keeps {partial, multiplier}; divide keeps {remainder, quotient}.
  always_comb begin
    w_sum   = {1'b0, r_acc[2*WIDTH-1:WIDTH]} + (r_acc[0] ? {1'b0, r_operand} : '0);
    w_shift = {r_acc[2*WIDTH-1:WIDTH], r_acc[WIDTH-1]};
    w_ge    = (w_shift >= {1'b0, r_operand});
    w_diff  = w_shift - {1'b0, r_operand};
    if (r_div) begin
      w_acc_next = {(w_ge ? w_diff[WIDTH-1:0] : w_shift[WIDTH-1:0]),
                    r_acc[WIDTH-2:0], w_ge};
    end else begin
      w_acc_next = {w_sum, r_acc[WIDTH-1:1]};
    end
  end

  always_comb begin
    w_quo     = w_acc_next[WIDTH-1:0];
    w_rem     = w_acc_next[2*WIDTH-1:WIDTH];
    w_quo_fix = r_neg_q ? -w_quo : w_quo;
    w_rem_fix = r_neg_r ? -w_rem : w_rem;
    if (r_div_zero) begin
      o_result = {r_dividend, {WIDTH{1'b1}}};
    end else if (r_div) begin
      o_result = {w_rem_fix, w_quo_fix};
    end else begin
      o_result = r_neg_q ? -w_acc_next : w_acc_next;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_acc      <= '0;
      r_operand  <= '0;
      r_dividend <= '0;
      r_div      <= 1'b0;
      r_neg_q    <= 1'b0;
      r_neg_r    <= 1'b0;
      r_div_zero <= 1'b0;
    end else if (i_start) begin
      r_acc      <= {{WIDTH{1'b0}}, w_a_mag};
      r_operand  <= w_b_mag;
      r_dividend <= i_a;
      r_div      <= i_div;
      r_neg_q    <= i_signed && (i_a[WIDTH-1] ^ i_b[WIDTH-1]);
      r_neg_r    <= i_signed && i_div && i_a[WIDTH-1];
      r_div_zero <= i_div && (i_b == '0);
    end else if (i_step) begin
      r_acc <= w_acc_next;
    end
  end

endmodule

// File: rtl/multicycle_alu.sv
// ALU with single-cycle logic/arith ops and iterative multiply/divide,
// sequenced by an IDLE/CALC/DONE FSM with registered results.
module multicycle_alu
  import alu_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int ITER  = ITER_DEFAULT
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             alu_en,
  input  logic [3:0]       alu_control,
  input  logic [WIDTH-1:0] alu_srcA,
  input  logic [WIDTH-1:0] alu_srcB,
  output logic [WIDTH-1:0] alu_result,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic             overflow,
  output logic             alu_zero,
  output logic             alu_done,
  output logic             busy
);

  localparam int         SHW        = $clog2(WIDTH);
  localparam logic [4:0] LAST_COUNT = 5'(ITER - 1);

  state_t             r_state;
  state_t             w_state_next;
  logic [4:0]         r_count;
  logic [WIDTH-1:0]   r_result;
  logic [WIDTH-1:0]   r_hi;
  logic [WIDTH-1:0]   r_lo;
  logic               r_overflow;
  logic               r_zero;

  logic               w_accept;
  logic               w_multi;
  logic               w_last;
  logic [WIDTH-1:0]   w_add;
  logic [WIDTH-1:0]   w_sub;
  logic [WIDTH-1:0]   w_alu_res;
  logic               w_alu_ovf;
  logic [2*WIDTH-1:0] w_md_result;

  assign w_multi  = is_multicycle(alu_control);
  assign w_accept = (r_state == ST_IDLE) && alu_en;
  assign w_last   = (r_state == ST_CALC) && (r_count == LAST_COUNT);

  mul_div_iter #(.WIDTH(WIDTH)) u_mul_div (
    .clk      (clk),
    .rst_n    (rst_n),
    .i_start  (w_accept && w_multi),
    .i_step   (r_state == ST_CALC),
    .i_signed ((alu_control == OP_MULT) || (alu_control == OP_DIV)),
    .i_div    ((alu_control == OP_DIV) || (alu_control == OP_DIVU)),
    .i_a      (alu_srcA),
    .i_b      (alu_srcB),
    .o_result (w_md_result)
  );

  always_comb begin
    w_add     = alu_srcA + alu_srcB;
    w_sub     = alu_srcA - alu_srcB;
    w_alu_res = '0;
    w_alu_ovf = 1'b0;
    case (alu_control)
      OP_ADD: begin
        w_alu_res = w_add;
        w_alu_ovf = (alu_srcA[WIDTH-1] == alu_srcB[WIDTH-1]) &&
                    (w_add[WIDTH-1] != alu_srcA[WIDTH-1]);
      end
      OP_SUB: begin
        w_alu_res = w_sub;
        w_alu_ovf = (alu_srcA[WIDTH-1] != alu_srcB[WIDTH-1]) &&
                    (w_sub[WIDTH-1] != alu_srcA[WIDTH-1]);
      end
      OP_AND:  w_alu_res = alu_srcA & alu_srcB;
      OP_OR:   w_alu_res = alu_srcA | alu_srcB;
      OP_XOR:  w_alu_res = alu_srcA ^ alu_srcB;
      OP_NOR:  w_alu_res = ~(alu_srcA | alu_srcB);
      OP_SLT:  w_alu_res = {{(WIDTH-1){1'b0}}, ($signed(alu_srcA) < $signed(alu_srcB))};
      OP_SLTU: w_alu_res = {{(WIDTH-1){1'b0}}, (alu_srcA < alu_srcB)};
      OP_SLL:  w_alu_res = alu_srcA << alu_srcB[SHW-1:0];
      OP_SRL:  w_alu_res = alu_srcA >> alu_srcB[SHW-1:0];
      OP_SRA:  w_alu_res = WIDTH'($signed(alu_srcA) >>> alu_srcB[SHW-1:0]);
      default: begin
        w_alu_res = '0;
        w_alu_ovf = 1'b0;
      end
    endcase
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      ST_IDLE: if (alu_en) w_state_next = w_multi ? ST_CALC : ST_DONE;
      ST_CALC: if (r_count == LAST_COUNT) w_state_next = ST_DONE;
      ST_DONE: w_state_next = ST_IDLE;
      default: w_state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
      r_count <= '0;
    end else begin
      r_state <= w_state_next;
      if (w_accept) begin
        r_count <= '0;
      end else if (r_state == ST_CALC) begin
        r_count <= r_count + 5'd1;
      end
    end
  end

  // Results change only on the edge that enters DONE.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_result   <= '0;
      r_overflow <= 1'b0;
      r_zero     <= 1'b1;
      r_hi       <= '0;
      r_lo       <= '0;
    end else if (w_accept && !w_multi) begin
      r_result   <= w_alu_res;
      r_overflow <= w_alu_ovf;
      r_zero     <= (w_alu_res == '0);
    end else if (w_last) begin
      r_hi       <= w_md_result[2*WIDTH-1:WIDTH];
      r_lo       <= w_md_result[WIDTH-1:0];
      r_result   <= w_md_result[WIDTH-1:0];
      r_overflow <= 1'b0;
      r_zero     <= (w_md_result[WIDTH-1:0] == '0);
    end
  end

  assign alu_result = r_result;
  assign hi         = r_hi;
  assign lo         = r_lo;
  assign overflow   = r_overflow;
  assign alu_zero   = r_zero;
  assign alu_done   = (r_state == ST_DONE);
  assign busy       = (r_state != ST_IDLE);

endmodule

// File: tb/tb_multicycle_alu.sv
// Directed, table-driven bench for multicycle_alu plus hand-written
// sequences for held request strobe and reset during an iteration.
module tb_multicycle_alu;

  logic        clk;
  logic        rst_n;
  logic        alu_en;
  logic [3:0]  alu_control;
  logic [31:0] alu_srcA;
  logic [31:0] alu_srcB;
  logic [31:0] alu_result;
  logic [31:0] hi;
  logic [31:0] lo;
  logic        overflow;
  logic        alu_zero;
  logic        alu_done;
  logic        busy;

  int checks = 0;
  int errors = 0;

  multicycle_alu #(.WIDTH(32), .ITER(32)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .alu_en      (alu_en),
    .alu_control (alu_control),
    .alu_srcA    (alu_srcA),
    .alu_srcB    (alu_srcB),
    .alu_result  (alu_result),
    .hi          (hi),
    .lo          (lo),
    .overflow    (overflow),
    .alu_zero    (alu_zero),
    .alu_done    (alu_done),
    .busy        (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [3:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] res;
    logic        ovf;
    logic [31:0] hi;
    logic [31:0] lo;
  } vec_t;

  vec_t vecs[$];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Called at a negedge with the DUT idle; returns at the negedge where
  // alu_done is seen (or the budget runs out).
  task automatic run_op(input logic [3:0] op, input logic [31:0] a,
                        input logic [31:0] b, output int lat);
    alu_control = op;
    alu_srcA    = a;
    alu_srcB    = b;
    alu_en      = 1'b1;
    @(posedge clk);
    @(negedge clk);
    alu_en = 1'b0;
    lat    = 1;
    while (!alu_done && lat < 100) begin
      @(negedge clk);
      lat++;
    end
  endtask

  initial begin
    int          lat;
    int          busy_cnt;
    int          done_cnt;
    logic [31:0] exp_hi;
    logic [31:0] exp_lo;
    int          exp_lat;

    // Single-cycle ops (hi/lo must stay at their reset value of 0)
    vecs.push_back('{4'h0, 32'h7FFF_FFFF, 32'h0000_0001, 32'h8000_0000, 1'b1, 32'h0, 32'h0});
    vecs.push_back('{4'h1, 32'h0000_0005, 32'h0000_0005, 32'h0000_0000, 1'b0, 32'h0, 32'h0});
    vecs.push_back('{4'hA, 32'h8000_0000, 32'h0000_0004, 32'hF800_0000, 1'b0, 32'h0, 32'h0});
    vecs.push_back('{4'h1, 32'h8000_0000, 32'h0000_0001, 32'h7FFF_FFFF, 1'b1, 32'h0, 32'h0});
    vecs.push_back('{4'h0, 32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0000, 1'b0, 32'h0, 32'h0});
    vecs.push_back('{4'h2, 32'hF0F0_F0F0, 32'hFF00_FF00, 32'hF000_F000, 1'b0, 32'h0, 32'h0});
    vecs.push_back('{4'h3, 32'hF0F0_F0F0, 32'h0F0F_0000, 32'hFFFF_F0F0, 1'b0, 32'h0, 32'h0});
    vecs.push_back('{4'h4, 32'hFFFF_0000, 32'hFF00_FF00, 32'h00FF_FF00, 1'b0, 32'h0, 32'h0});
    vecs.push_back('{4'h5, 32'h0000_0000, 32'h0000_0000, 32'hFFFF_FFFF, 1'b0, 32'h0, 32'h0});
    vecs.push_back('{4'h6, 32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0001, 1'b0, 32'h0, 32'h0});
    vecs.push_back('{4'h7, 32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0000, 1'b0, 32'h0, 32'h0});
    vecs.push_back('{4'h8, 32'h0000_0001, 32'h0000_001F, 32'h8000_0000, 1'b0, 32'h0, 32'h0});
    vecs.push_back('{4'h8, 32'h0000_0001, 32'h0000_0021, 32'h0000_0002, 1'b0, 32'h0, 32'h0});
    vecs.push_back('{4'h9, 32'h8000_0000, 32'h0000_0004, 32'h0800_0000, 1'b0, 32'h0, 32'h0});
    vecs.push_back('{4'hF, 32'h0000_0005, 32'h0000_0006, 32'h0000_0000, 1'b0, 32'h0, 32'h0});
    // Multiply/divide ops: result equals the new lo
    vecs.push_back('{4'hB, 32'hFFFF_FFFE, 32'h0000_0003, 32'hFFFF_FFFA, 1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFA});
    vecs.push_back('{4'hC, 32'hFFFF_FFFE, 32'h0000_0003, 32'hFFFF_FFFA, 1'b0, 32'h0000_0002, 32'hFFFF_FFFA});
    vecs.push_back('{4'hC, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 32'hFFFF_FFFE, 32'h0000_0001});
    vecs.push_back('{4'hB, 32'h0000_0000, 32'h0000_0005, 32'h0000_0000, 1'b0, 32'h0000_0000, 32'h0000_0000});
    vecs.push_back('{4'hD, 32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFD, 1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFD});
    vecs.push_back('{4'hD, 32'h0000_0007, 32'hFFFF_FFFE, 32'hFFFF_FFFD, 1'b0, 32'h0000_0001, 32'hFFFF_FFFD});
    vecs.push_back('{4'hD, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1'b0, 32'h0000_0000, 32'h8000_0000});
    vecs.push_back('{4'hE, 32'h0000_0064, 32'h0000_0007, 32'h0000_000E, 1'b0, 32'h0000_0002, 32'h0000_000E});
    vecs.push_back('{4'hE, 32'h0000_0007, 32'h0000_0000, 32'hFFFF_FFFF, 1'b0, 32'h0000_0007, 32'hFFFF_FFFF});
    vecs.push_back('{4'hD, 32'hFFFF_FFF9, 32'h0000_0000, 32'hFFFF_FFFF, 1'b0, 32'hFFFF_FFF9, 32'hFFFF_FFFF});
    // Single-cycle op after a divide: hi/lo must hold
    vecs.push_back('{4'h0, 32'h0000_0002, 32'h0000_0003, 32'h0000_0005, 1'b0, 32'hFFFF_FFF9, 32'hFFFF_FFFF});

    rst_n       = 1'b0;
    alu_en      = 1'b0;
    alu_control = 4'h0;
    alu_srcA    = '0;
    alu_srcB    = '0;
    repeat (3) @(negedge clk);

    chk("rst_result",   {32'h0, alu_result}, 64'h0);
    chk("rst_hi",       {32'h0, hi},         64'h0);
    chk("rst_lo",       {32'h0, lo},         64'h0);
    chk("rst_overflow", {63'h0, overflow},   64'h0);
    chk("rst_zero",     {63'h0, alu_zero},   64'h1);
    chk("rst_done",     {63'h0, alu_done},   64'h0);
    chk("rst_busy",     {63'h0, busy},       64'h0);

    // First accept on the very first edge after reset release
    rst_n = 1'b1;
    run_op(4'h0, 32'h1, 32'h1, lat);
    $display("first op after reset: res=%h lat=%0d", alu_result, lat);
    chk("first_lat", 64'(lat), 64'd1);
    chk("first_res", {32'h0, alu_result}, 64'h2);
    @(negedge clk);

    exp_hi = 32'h0;
    exp_lo = 32'h0;
    for (int i = 0; i < vecs.size(); i++) begin
      exp_lat = (vecs[i].op >= 4'hB && vecs[i].op <= 4'hE) ? 33 : 1;
      exp_hi  = vecs[i].hi;
      exp_lo  = vecs[i].lo;
      run_op(vecs[i].op, vecs[i].a, vecs[i].b, lat);
      $display("op=%h a=%h b=%h -> res=%h ovf=%b zero=%b hi=%h lo=%h lat=%0d",
               vecs[i].op, vecs[i].a, vecs[i].b, alu_result, overflow, alu_zero, hi, lo, lat);
      chk($sformatf("v%0d_lat", i), 64'(lat), 64'(exp_lat));
      chk($sformatf("v%0d_res", i), {32'h0, alu_result}, {32'h0, vecs[i].res});
      chk($sformatf("v%0d_ovf", i), {63'h0, overflow}, {63'h0, vecs[i].ovf});
      chk($sformatf("v%0d_zero", i), {63'h0, alu_zero}, {63'h0, (vecs[i].res == 32'h0)});
      chk($sformatf("v%0d_hilo", i), {hi, lo}, {exp_hi, exp_lo});
      chk($sformatf("v%0d_busy", i), {63'h0, busy}, 64'h1);
      @(negedge clk);
      chk($sformatf("v%0d_done_pulse", i), {63'h0, alu_done}, 64'h0);
      chk($sformatf("v%0d_idle", i), {63'h0, busy}, 64'h0);
      chk($sformatf("v%0d_hold", i), {32'h0, alu_result}, {32'h0, vecs[i].res});
    end

    // alu_en held high across a MULT: one accept, operand changes ignored
    alu_control = 4'hB;
    alu_srcA    = 32'hFFFF_FFFE;
    alu_srcB    = 32'h0000_0003;
    alu_en      = 1'b1;
    busy_cnt    = 0;
    done_cnt    = 0;
    for (int c = 1; c <= 34; c++) begin
      @(negedge clk);
      if (busy) busy_cnt++;
      if (alu_done) done_cnt++;
      if (c == 5) alu_srcA = 32'h1234_5678;
      if (c == 34) begin
        alu_control = 4'h0;
        alu_srcA    = 32'h2;
        alu_srcB    = 32'h3;
      end
    end
    $display("held-en MULT: busy_cycles=%0d done_pulses=%0d hi=%h lo=%h",
             busy_cnt, done_cnt, hi, lo);
    chk("held_busy_cycles", 64'(busy_cnt), 64'd33);
    chk("held_done_pulses", 64'(done_cnt), 64'd1);
    chk("held_hilo", {hi, lo}, 64'hFFFF_FFFF_FFFF_FFFA);
    @(negedge clk);
    alu_en = 1'b0;
    $display("held-en second accept: done=%b res=%h", alu_done, alu_result);
    chk("held_second_done", {63'h0, alu_done}, 64'h1);
    chk("held_second_res", {32'h0, alu_result}, 64'h5);
    @(negedge clk);

    // Reset pulsed during CALC cycle 10 aborts the MULT
    alu_control = 4'hB;
    alu_srcA    = 32'h3;
    alu_srcB    = 32'h5;
    alu_en      = 1'b1;
    @(posedge clk);
    @(negedge clk);
    alu_en = 1'b0;
    repeat (9) @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("abort_busy", {63'h0, busy}, 64'h0);
    chk("abort_done", {63'h0, alu_done}, 64'h0);
    chk("abort_hilo", {hi, lo}, 64'h0);
    chk("abort_zero", {63'h0, alu_zero}, 64'h1);
    @(negedge clk);
    rst_n    = 1'b1;
    done_cnt = 0;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      if (alu_done) done_cnt++;
    end
    $display("after abort: done_pulses=%0d hi=%h lo=%h busy=%b", done_cnt, hi, lo, busy);
    chk("abort_no_done", 64'(done_cnt), 64'd0);
    chk("abort_hilo_after", {hi, lo}, 64'h0);
    run_op(4'h0, 32'h7, 32'h8, lat);
    $display("ADD after abort: res=%h lat=%0d", alu_result, lat);
    chk("abort_add_lat", 64'(lat), 64'd1);
    chk("abort_add_res", {32'h0, alu_result}, 64'hF);
    @(negedge clk);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
